// File: rtl/spi_pkg.sv
//------------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI command framer: the framer state encoding,
// the CRC-8 polynomial and the bit layout of the instruction byte.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  // Framer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_CS = 2'd2
  } state_t;

  // CRC-8 generator polynomial (x^8 + x^2 + x + 1), MSB-first
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Instruction byte layout: {rw, addr[6:0]}
  localparam int INSTR_RW_BIT   = 7;
  localparam int INSTR_ADDR_MSB = 6;
  localparam int INSTR_ADDR_LSB = 0;

  // Build the instruction byte from the command fields
  function automatic logic [7:0] make_instr(input logic rw, input logic [6:0] addr);
    logic [7:0] b;
    b = 8'h00;
    b[INSTR_RW_BIT] = rw;
    b[INSTR_ADDR_MSB:INSTR_ADDR_LSB] = addr;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_crc8.sv
//------------------------------------------------------------------------------
// spi_crc8
// One byte-wide step of a CRC-8 (MSB-first, polynomial from spi_pkg).
// Purely combinational: o_crc = f(i_crc, i_byte).
// Ports:
//   i_crc   in  8  running CRC value
//   i_byte  in  8  byte being folded in
//   o_crc   out 8  CRC after folding in i_byte
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_crc8
  import spi_pkg::*;
(
  input  logic [7:0] i_crc,
  input  logic [7:0] i_byte,
  output logic [7:0] o_crc
);

  logic [7:0] w_acc;

  // Process the eight message bits MSB-first; the data byte is XORed into
  // the register up front, which is equivalent to bit-serial feeding.
  always_comb begin
    w_acc = i_crc ^ i_byte;
    for (int i = 0; i < 8; i++) begin
      if (w_acc[7]) begin
        w_acc = {w_acc[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        w_acc = {w_acc[6:0], 1'b0};
      end
    end
    o_crc = w_acc;
  end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_framer.sv
//------------------------------------------------------------------------------
// spi_cmd_framer
// Turns one register-access command (rw, 7-bit address, 0..MAX_BYTES payload
// bytes) into a byte stream for spi_master_byte on its have_data/data/rdreq
// interface. have_data stays high for the whole frame so chip select is held;
// after the last byte the framer waits for spi_cs_n to rise before taking the
// next command.
//
// Optional build macro: SPI_FRAMER_CRC8_EN - appends a CRC-8 byte computed
// over the instruction byte and all payload/dummy bytes.
//
// Ports:
//   clk         in   1            system clock
//   rst         in   1            asynchronous reset, active-low
//   cmd_valid   in   1            command present
//   cmd_ready   out  1            framer can accept a command
//   cmd_rw      in   1            1=read, 0=write
//   cmd_addr    in   7            register address
//   cmd_len     in   LEN_W        payload byte count
//   cmd_data    in   8*MAX_BYTES  write payload, byte k at [8k+7:8k]
//   cmd_err     out  1            one-cycle pulse: command rejected
//   have_data   out  1            data_o valid
//   data_o      out  8            current byte
//   rdreq       in   1            pop strobe from SPI master
//   spi_cs_n    in   1            SPI master chip select
//   busy        out  1            frame in progress
//   frame_done  out  1            one-cycle pulse at end of frame
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_cmd_framer
  import spi_pkg::*;
#(
  parameter int         MAX_BYTES  = 8,
  parameter logic [7:0] DUMMY_BYTE = 8'h00,
  parameter int         LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [6:0]             cmd_addr,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic [8*MAX_BYTES-1:0] cmd_data,
  output logic                   cmd_err,
  output logic                   have_data,
  output logic [7:0]             data_o,
  input  logic                   rdreq,
  input  logic                   spi_cs_n,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int IDX_W = LEN_W + 1;

`ifdef SPI_FRAMER_CRC8_EN
  localparam logic [IDX_W-1:0] c_EXTRA = IDX_W'(2);
`else
  localparam logic [IDX_W-1:0] c_EXTRA = IDX_W'(1);
`endif

  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_BYTES);

  // Registered state
  state_t                 r_state;
  logic                   r_rw;
  logic [LEN_W-1:0]       r_len;
  logic [8*MAX_BYTES-1:0] r_data;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_have;
  logic [7:0]             r_dout;
  logic                   r_err;
  logic                   r_done;

  // Next-state / control
  state_t                 w_state_nxt;
  logic                   w_have_nxt;
  logic [7:0]             w_dout_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   w_err_nxt;
  logic                   w_done_nxt;
  logic                   w_load;
  logic                   w_pop;
  logic [IDX_W-1:0]       w_idx_inc;
  logic [IDX_W-1:0]       w_total;
  logic [IDX_W-1:0]       w_pay_sel;
  logic [7:0]             w_pay_byte;
  logic [7:0]             w_tail_byte;
  logic [7:0]             w_next_byte;

  // r_idx is the position of the byte currently on data_o:
  // 0 = instruction, 1..len = payload, len+1 = CRC (when enabled).
  assign w_pop     = (r_state == ST_SEND) && r_have && rdreq;
  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_total   = IDX_W'(r_len) + c_EXTRA;

  // Payload position k (1..len) carries write byte len-k, i.e. MSB-first
  assign w_pay_sel = IDX_W'(r_len) - w_idx_inc;

  always_comb begin
    w_pay_byte = 8'h00;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (w_pay_sel == IDX_W'(b)) begin
        w_pay_byte = r_data[8*b +: 8];
      end
    end
  end

`ifdef SPI_FRAMER_CRC8_EN
  logic [7:0] r_crc;
  logic [7:0] w_crc_next;

  // w_crc_next folds in the byte currently on data_o, so when the final
  // payload byte is popped it already equals the CRC of the whole frame.
  spi_crc8 u_crc8 (
    .i_crc  (r_crc),
    .i_byte (r_dout),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_crc <= 8'h00;
    end else if (w_load) begin
      r_crc <= 8'h00;
    end else if (w_pop && (r_idx <= IDX_W'(r_len))) begin
      r_crc <= w_crc_next;
    end
  end

  assign w_tail_byte = w_crc_next;
`else
  // No trailing byte exists in this build; the value is never presented
  assign w_tail_byte = DUMMY_BYTE;
`endif

  always_comb begin
    if (w_idx_inc <= IDX_W'(r_len)) begin
      w_next_byte = r_rw ? DUMMY_BYTE : w_pay_byte;
    end else begin
      w_next_byte = w_tail_byte;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt = r_state;
    w_have_nxt  = r_have;
    w_dout_nxt  = r_dout;
    w_idx_nxt   = r_idx;
    w_err_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len <= c_MAX_LEN) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SEND;
            w_have_nxt  = 1'b1;
            w_dout_nxt  = make_instr(cmd_rw, cmd_addr);
            w_idx_nxt   = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (w_pop) begin
          w_idx_nxt = w_idx_inc;
          if (w_idx_inc == w_total) begin
            w_have_nxt  = 1'b0;
            w_state_nxt = ST_WAIT_CS;
          end else begin
            w_dout_nxt = w_next_byte;
          end
        end
      end

      ST_WAIT_CS: begin
        if (spi_cs_n) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_have_nxt  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rw   <= 1'b0;
      r_len  <= '0;
      r_data <= '0;
      r_idx  <= '0;
      r_have <= 1'b0;
      r_dout <= 8'h00;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_have <= w_have_nxt;
      r_dout <= w_dout_nxt;
      r_idx  <= w_idx_nxt;
      r_err  <= w_err_nxt;
      r_done <= w_done_nxt;
      if (w_load) begin
        r_rw   <= cmd_rw;
        r_len  <= cmd_len;
        r_data <= cmd_data;
      end
    end
  end

  // Gated by rst so the framer advertises no readiness while held in reset
  assign cmd_ready  = rst && (r_state == ST_IDLE);
  assign cmd_err    = r_err;
  assign have_data  = r_have;
  assign data_o     = r_dout;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_framer.sv
//------------------------------------------------------------------------------
// tb_spi_cmd_framer
// Directed bench for spi_cmd_framer. Expected bytes, frame_done and cmd_err
// events are queued when a command is issued; a monitor compares them when
// the DUT presents them.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_cmd_framer;

  localparam int MAX_BYTES = 8;
  localparam int LEN_W     = $clog2(MAX_BYTES + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic                   cmd_rw = 1'b0;
  logic [6:0]             cmd_addr = '0;
  logic [LEN_W-1:0]       cmd_len = '0;
  logic [8*MAX_BYTES-1:0] cmd_data = '0;
  logic                   cmd_err;
  logic                   have_data;
  logic [7:0]             data_o;
  logic                   rdreq = 1'b0;
  logic                   spi_cs_n = 1'b1;
  logic                   busy;
  logic                   frame_done;

  spi_cmd_framer #(.MAX_BYTES(MAX_BYTES), .DUMMY_BYTE(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .cmd_err    (cmd_err),
    .have_data  (have_data),
    .data_o     (data_o),
    .rdreq      (rdreq),
    .spi_cs_n   (spi_cs_n),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int         done_q[$];
  int         err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Monitor: compares DUT events against the queued expectations
  always @(negedge clk) begin
    if (rst) begin
      if (have_data && rdreq) begin
        if (exp_q.size() == 0) fail_now("byte", $sformatf("popped 0x%0h, expected no byte", data_o));
        else check("byte", data_o, exp_q.pop_front());
      end
      if (frame_done) begin
        if (done_q.size() == 0) fail_now("frame_done", "got pulse, expected none");
        else begin
          void'(done_q.pop_front());
          check("frame_done_busy", busy, 0);
        end
      end
      if (cmd_err) begin
        if (err_q.size() == 0) fail_now("cmd_err", "got pulse, expected none");
        else begin
          void'(err_q.pop_front());
          check("cmd_err_have_data", have_data, 0);
        end
      end
    end
  end

  // Queue the byte stream a command must produce; returns its length
  task automatic push_frame(input logic rw, input logic [6:0] addr, input int len,
                            input logic [8*MAX_BYTES-1:0] data, output int nbytes);
    logic [7:0] b, crc;
    crc = 8'h00;
    b = {rw, addr};
    exp_q.push_back(b);
    crc = crc8(crc, b);
    for (int k = 1; k <= len; k++) begin
      b = rw ? 8'h00 : data[8*(len-k) +: 8];
      exp_q.push_back(b);
      crc = crc8(crc, b);
    end
    nbytes = 1 + len;
`ifdef SPI_FRAMER_CRC8_EN
    exp_q.push_back(crc);
    nbytes++;
`endif
  endtask

  task automatic issue(input logic rw, input logic [6:0] addr, input int len,
                       input logic [8*MAX_BYTES-1:0] data);
    @(posedge clk); #1;
    cmd_rw = rw; cmd_addr = addr; cmd_len = LEN_W'(len); cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    spi_cs_n  = 1'b0;
  endtask

  task automatic wait_have(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (have_data) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Pop n bytes, idling one cycle before each pop to check the byte holds
  task automatic run_pops(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wait_have(ok);
      if (!ok) begin
        fail_now("have_data_timeout", "have_data stayed 0, expected 1");
        return;
      end
      if (exp_q.size() > 0) check("byte_presented", data_o, exp_q[0]);
      check("busy_in_frame", busy, 1);
      check("ready_in_frame", cmd_ready, 0);
      @(posedge clk); #1;
      if (exp_q.size() > 0) check("byte_stable", data_o, exp_q[0]);
      rdreq = 1'b1;
      @(posedge clk); #1;
      rdreq = 1'b0;
    end
    check("have_after_last", have_data, 0);
    check("busy_wait_cs", busy, 1);
    // A pop while have_data is low must be ignored
    rdreq = 1'b1;
    @(posedge clk); #1;
    rdreq = 1'b0;
    check("have_after_stray_rdreq", have_data, 0);
    check("busy_after_stray_rdreq", busy, 1);
  endtask

  task automatic finish_frame();
    bit ok;
    done_q.push_back(1);
    spi_cs_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("busy_timeout", "busy stayed 1 after cs_n rose, expected 0");
      return;
    end
    check("frame_done_first_idle", frame_done, 1);
    check("ready_first_idle", cmd_ready, 1);
  endtask

  task automatic full_frame(input logic rw, input logic [6:0] addr, input int len,
                            input logic [8*MAX_BYTES-1:0] data);
    int n;
    push_frame(rw, addr, len, data, n);
    issue(rw, addr, len, data);
    check("have_after_accept", have_data, 1);
    check("instr_byte", data_o, {24'h0, rw, addr});
    run_pops(n);
    finish_frame();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_have_data", have_data, 0);
    check("rst_data_o", data_o, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b1;
    #1;
    check("ready_after_release", cmd_ready, 1);

    // 1: write 0x15, len 2 -> 0x15, 0xA5, 0x5A
    full_frame(1'b0, 7'h15, 2, 64'hA55A);

    // 2: read 0x7F, len 3 -> 0xFF, 0x00, 0x00, 0x00
    full_frame(1'b1, 7'h7F, 3, 64'h0);

    // 3: write 0x01, len 0 -> 0x01 (then 0x07 with CRC)
    full_frame(1'b0, 7'h01, 0, 64'h0);
`ifdef SPI_FRAMER_CRC8_EN
    check("crc_of_0x01", crc8(8'h00, 8'h01), 8'h07);
`endif

    // 4: len 9 exceeds MAX_BYTES -> cmd_err, nothing sent
    err_q.push_back(1);
    issue(1'b0, 7'h22, 9, 64'h0);
    spi_cs_n = 1'b1;
    check("err_have_data", have_data, 0);
    check("err_cmd_ready", cmd_ready, 1);
    check("err_busy", busy, 0);
    check("err_pulse", cmd_err, 1);
    @(posedge clk); #1;
    check("err_one_cycle", cmd_err, 0);
    check("err_have_data_later", have_data, 0);

    // Max-length write: 8 bytes MSB-first
    full_frame(1'b0, 7'h40, 8, 64'h0102030405060708);

    // 5: command held during a frame is taken in the first IDLE cycle
    push_frame(1'b0, 7'h33, 1, 64'hC3, n);
    issue(1'b0, 7'h33, 1, 64'hC3);
    cmd_rw = 1'b1; cmd_addr = 7'h2A; cmd_len = LEN_W'(2); cmd_data = 64'h0;
    cmd_valid = 1'b1;
    begin
      int n2;
      push_frame(1'b1, 7'h2A, 2, 64'h0, n2);
      run_pops(n);
      check("held_ready_low", cmd_ready, 0);
      finish_frame();
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      spi_cs_n  = 1'b0;
      check("held_accept_have", have_data, 1);
      check("held_accept_instr", data_o, 32'hAA);
      run_pops(n2);
      finish_frame();
    end

    // 6: reset in the middle of a frame
    exp_q.push_back(8'h15);
    issue(1'b0, 7'h15, 2, 64'hA55A);
    begin
      bit ok;
      wait_have(ok);
      rdreq = 1'b1;
      @(posedge clk); #1;
      rdreq = 1'b0;
    end
    check("mid_frame_byte", data_o, 8'hA5);
    rst = 1'b0;
    #1;
    check("midrst_have_data", have_data, 0);
    check("midrst_data_o", data_o, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_cmd_err", cmd_err, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    spi_cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_ready_after", cmd_ready, 1);
    full_frame(1'b0, 7'h15, 2, 64'hA55A);

    repeat (3) @(posedge clk);
    #1;
    check("exp_bytes_left", exp_q.size(), 0);
    check("done_events_left", done_q.size(), 0);
    check("err_events_left", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/spi_cmd_framer.md
Name: spi_cmd_framer

Overview:
- Upstream byte source for spi_master_byte; replaces the show-ahead FIFO that normally feeds it.
- Accepts one register-access command (R/W flag, 7-bit address, payload of 0..MAX_BYTES bytes).
- Serializes the command as an instruction byte followed by payload or dummy bytes on the have_data/data/rdreq byte interface.
- Holds have_data high for the whole frame so the SPI master keeps cs_n low, then waits for cs_n to rise before accepting the next command.

Parameters:
- MAX_BYTES, 8, maximum payload bytes per frame (1..16).
- DUMMY_BYTE, 8'h00, byte sent in payload slots of a read frame.
- LEN_W, $clog2(MAX_BYTES+1), width of cmd_len (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  framer can accept a command
- cmd_rw  in  1  1=read, 0=write
- cmd_addr  in  7  register address
- cmd_len  in  LEN_W  payload byte count, 0..MAX_BYTES
- cmd_data  in  8*MAX_BYTES  write payload; byte k sits at [8k+7:8k]
- cmd_err  out  1  one-cycle pulse: command rejected
- have_data  out  1  data_o valid; to SPI master have_data
- data_o  out  8  current byte; to SPI master data_i
- rdreq  in  1  pop strobe from SPI master
- spi_cs_n  in  1  SPI master cs_n, used to detect end of transaction
- busy  out  1  frame in progress (not IDLE)
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after release; cmd_err=0, have_data=0, data_o=8'h00, busy=0, frame_done=0, state=IDLE.
- Reset asserted mid-frame clears everything immediately. No partial-frame recovery; the SPI master shares rst.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_len<=MAX_BYTES: latch rw, addr, len, data; go to SEND.
  - On cmd_valid with cmd_len>MAX_BYTES: pulse cmd_err the next cycle, stay in IDLE, send nothing.
- State SEND:
  - Cycle after acceptance: have_data=1, data_o={cmd_rw,cmd_addr}.
  - On rdreq, the next cycle presents the next byte.
  - Write payload order: byte len-1 first, down to byte 0 (MSB-first).
  - Read payload: DUMMY_BYTE repeated len times.
  - After the pop of the final byte, have_data=0 in the next cycle; go to WAIT_CS.
  - Total bytes per frame = 1+len.
- State WAIT_CS:
  - have_data=0.
  - When spi_cs_n==1, pulse frame_done for one cycle and go to IDLE.
- cmd_ready=0 in SEND and WAIT_CS. A cmd_valid held during a frame is accepted in the first IDLE cycle.
- rdreq while have_data==0 is ignored, and the byte index does not move.
- data_o only changes on acceptance or on rdreq. It is stable while have_data=1 and no pop occurs.
- Byte index counter width is LEN_W+1. No wrap is possible because len<=MAX_BYTES is checked at acceptance.
- busy = (state != IDLE).

Optional Feature:
- Macro SPI_FRAMER_CRC8_EN.
- Defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first) is computed over the instruction byte and all payload/dummy bytes.
  - The CRC is appended as one trailing byte, so frame length = 2+len.
  - The CRC is updated on each rdreq pop of a non-CRC byte.
- Undefined: no CRC logic and no trailing byte.

Decomposition:
- Shared package spi_pkg:
  - state encoding (IDLE, SEND, WAIT_CS)
  - CRC8_POLY=8'h07
  - instruction-byte field positions (RW bit 7, ADDR [6:0])
- Sub-module spi_crc8: byte-wide combinational CRC step, crc_next = f(crc, byte). Instantiated only under SPI_FRAMER_CRC8_EN.

Test Plan:
1. Write, addr 0x15, len 2, cmd_data[15:0]=0xA55A, rdreq one cycle after each have_data → bytes 0x15, 0xA5, 0x5A. have_data low after the third pop. frame_done one cycle after spi_cs_n driven high.
2. Read, addr 0x7F, len 3 → bytes 0xFF, 0x00, 0x00, 0x00. busy high from acceptance until frame_done.
3. Write, len 0, addr 0x01 → single byte 0x01, then WAIT_CS. With SPI_FRAMER_CRC8_EN the bytes are 0x01, 0x07.
4. len 9 with MAX_BYTES=8 → cmd_err pulse, have_data stays 0, cmd_ready stays 1.
5. Second cmd_valid held during a frame → cmd_ready=0 until frame_done. Accepted in the first IDLE cycle; next instruction byte appears one cycle later.
6. rst low while data_o=0xA5 is mid-frame → have_data, data_o, busy, frame_done and cmd_err all 0 immediately. After release, cmd_ready=1 and a new frame runs cleanly.
